// File: rtl/c2f_req_buf.sv
// C2F request buffer: queues core-to-fabric requests, injects them into free ring
// slots, and filters ring responses against per-thread outstanding reads.
package c2f_req_buf_pkg;
  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2,
    WR_RSP = 2'd3
  } t_opcode;
endpackage

module c2f_req_buf
  import c2f_req_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          QClk,
  input  logic          RstQnnnH,
  input  logic          C2F_ReqValidQ500H,
  input  t_opcode       C2F_ReqOpcodeQ500H,
  input  logic [1:0]    C2F_ReqThreadIDQ500H,
  input  logic [AW-1:0] C2F_ReqAddressQ500H,
  input  logic [AW-1:0] C2F_ReqDataQ500H,
  output logic          C2F_RspStall,
  input  logic          RingSlotFreeQ501H,
  output logic          RingReqValidQ501H,
  output t_opcode       RingReqOpcodeQ501H,
  output logic [1:0]    RingReqThreadIDQ501H,
  output logic [AW-1:0] RingReqAddressQ501H,
  output logic [AW-1:0] RingReqDataQ501H,
  input  logic          RingRspValidQ501H,
  input  t_opcode       RingRspOpcodeQ501H,
  input  logic [1:0]    RingRspThreadIDQ501H,
  input  logic [AW-1:0] RingRspDataQ501H,
  output logic          C2F_RspValidQ502H,
  output t_opcode       C2F_RspOpcodeQ502H,
  output logic [1:0]    C2F_RspThreadIDQ502H,
  output logic [AW-1:0] C2F_RspDataQ502H,
  output logic [3:0]    OutstandingRd,
  output logic          SpuriousRspErr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0]   count;

  t_opcode       opMem   [DEPTH];
  logic [1:0]    tidMem  [DEPTH];
  logic [AW-1:0] addrMem [DEPTH];
  logic [AW-1:0] dataMem [DEPTH];

  logic fifoFull, notEmpty, pushEn, popEn;

  assign fifoFull = (count == DEPTH_C);
  assign notEmpty = (count != '0);
  // Inject is suppressed while reset is asserted so a mid-run reset emits no ring traffic.
  assign popEn    = notEmpty && RingSlotFreeQ501H && !RstQnnnH;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign pushEn   = C2F_ReqValidQ500H && (!fifoFull || popEn);

  assign C2F_RspStall      = fifoFull;
  assign RingReqValidQ501H = popEn;

  always_comb begin
    RingReqOpcodeQ501H   = RD;
    RingReqThreadIDQ501H = '0;
    RingReqAddressQ501H  = '0;
    RingReqDataQ501H     = '0;
    if (notEmpty) begin
      RingReqOpcodeQ501H   = opMem[rdPtr];
      RingReqThreadIDQ501H = tidMem[rdPtr];
      RingReqAddressQ501H  = addrMem[rdPtr];
      RingReqDataQ501H     = dataMem[rdPtr];
    end
  end

  always_ff @(posedge QClk) begin
    if (pushEn) begin
      opMem[wrPtr]   <= C2F_ReqOpcodeQ500H;
      tidMem[wrPtr]  <= C2F_ReqThreadIDQ500H;
      addrMem[wrPtr] <= C2F_ReqAddressQ500H;
      dataMem[wrPtr] <= C2F_ReqDataQ500H;
    end
  end

  logic [3:0] rdSet, rdClr;
  logic       rspAccept, rspSpurious, dupRd;

  always_comb begin
    rdSet       = '0;
    rdClr       = '0;
    rspAccept   = 1'b0;
    rspSpurious = 1'b0;
    if (pushEn && C2F_ReqOpcodeQ500H == RD)
      rdSet[C2F_ReqThreadIDQ500H] = 1'b1;
    if (RingRspValidQ501H) begin
      case (RingRspOpcodeQ501H)
        RD_RSP: begin
          if (OutstandingRd[RingRspThreadIDQ501H]) begin
            rdClr[RingRspThreadIDQ501H] = 1'b1;
            rspAccept = 1'b1;
          end else begin
            rspSpurious = 1'b1;
          end
        end
        WR_RSP:  rspAccept = 1'b1;
        default: ;
      endcase
    end
    // A new read from a thread whose old read retires this same edge is not a duplicate.
    dupRd = pushEn && (C2F_ReqOpcodeQ500H == RD) &&
            OutstandingRd[C2F_ReqThreadIDQ500H] && !rdClr[C2F_ReqThreadIDQ500H];
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      rdPtr                <= '0;
      wrPtr                <= '0;
      count                <= '0;
      OutstandingRd        <= '0;
      SpuriousRspErr       <= 1'b0;
      C2F_RspValidQ502H    <= 1'b0;
      C2F_RspOpcodeQ502H   <= RD;
      C2F_RspThreadIDQ502H <= '0;
      C2F_RspDataQ502H     <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
      OutstandingRd <= (OutstandingRd & ~rdClr) | rdSet;
      if (rspSpurious || dupRd) SpuriousRspErr <= 1'b1;
      // Response stage boundary: Q501H ring response -> Q502H wrapper response.
      C2F_RspValidQ502H <= rspAccept;
      if (rspAccept) begin
        C2F_RspOpcodeQ502H   <= RingRspOpcodeQ501H;
        C2F_RspThreadIDQ502H <= RingRspThreadIDQ501H;
        C2F_RspDataQ502H     <= RingRspDataQ501H;
      end
    end
  end

endmodule

// File: doc/c2f_req_buf.md
Name: c2f_req_buf

Overview:
- Sits between the core data-memory wrapper's C2F (core-to-fabric) request outputs and the ring fabric.
- Buffers remote read/write requests in a FIFO and injects them into free ring slots.
- Tracks one outstanding remote read per thread and filters ring responses.
- Delivers accepted responses to the wrapper's C2F_Rsp*Q502H inputs and drives C2F_RspStall back-pressure.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- AW, 32, address and data width.

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  reset; synchronous, active-high
- C2F_ReqValidQ500H  in  1  request from core wrapper
- C2F_ReqOpcodeQ500H  in  t_opcode  RD or WR
- C2F_ReqThreadIDQ500H  in  2  issuing thread
- C2F_ReqAddressQ500H  in  32  target address
- C2F_ReqDataQ500H  in  32  write data
- C2F_RspStall  out  1  FIFO full; core must hold the request
- RingSlotFreeQ501H  in  1  ring slot available this cycle
- RingReqValidQ501H  out  1  inject request into ring
- RingReqOpcodeQ501H  out  t_opcode
- RingReqThreadIDQ501H  out  2
- RingReqAddressQ501H  out  32
- RingReqDataQ501H  out  32
- RingRspValidQ501H  in  1  response arriving from ring
- RingRspOpcodeQ501H  in  t_opcode  RD_RSP/WR_RSP per lotr_pkg
- RingRspThreadIDQ501H  in  2
- RingRspDataQ501H  in  32
- C2F_RspValidQ502H  out  1  response to wrapper
- C2F_RspOpcodeQ502H  out  t_opcode
- C2F_RspThreadIDQ502H  out  2
- C2F_RspDataQ502H  out  32
- OutstandingRd  out  4  per-thread read-pending bits, bit n = thread n
- SpuriousRspErr  out  1  sticky error flag

Behaviour:
- Reset (RstQnnnH=1 at a QClk edge): FIFO emptied (rd/wr pointers and count = 0). All outputs 0: C2F_RspStall=0, RingReqValidQ501H=0, C2F_RspValidQ502H=0, OutstandingRd=4'b0, SpuriousRspErr=0, all data, address and opcode outputs = 0. Reset mid-operation discards buffered requests and pending reads with no ring traffic.
- Push: when C2F_ReqValidQ500H=1 and count<DEPTH, the request is written at the next edge.
- Full: C2F_RspStall = (count==DEPTH), combinational from registered count. A push while full is dropped; the wrapper guarantees it does not push while stalled.
- Inject: RingReqValidQ501H = (count!=0) && RingSlotFreeQ501H. Ring* fields come from the head entry. Pop at the edge where the inject signal is 1. No bypass, so minimum latency is push at cycle N, inject at N+1.
- Simultaneous push and pop: count unchanged, and this is legal when full. Stall stays 1 for that cycle because it is evaluated from the registered count.
- Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Read tracking: OutstandingRd[t] is set on the push edge of an RD request from thread t.
- Response qualify: a ring response is accepted when RingRspValidQ501H=1 and either:
  - opcode=RD_RSP and OutstandingRd[tid]=1, which also clears OutstandingRd[tid] at the same edge; or
  - opcode=WR_RSP, accepted unconditionally since writes are posted.
- Accepted responses are registered into C2F_Rsp*Q502H: 1-cycle latency, valid for exactly 1 cycle, fields held until the next accepted response.
- Spurious response: an RD_RSP with OutstandingRd[tid]=0 is dropped, C2F_RspValidQ502H=0, and SpuriousRspErr is set. The flag stays set until reset.
- Set and clear of the same thread in the same cycle: the clear applies to the old request, and set wins (final bit = 1).
- A second RD push from a thread with its bit already set: bit stays 1 and SpuriousRspErr is set. Each thread is allowed only one outstanding read.

Test Plan:
- Basic read:
  - Stimulus: RD T2 addr 0x0200_0100 pushed at cycle 0, RingSlotFree=1.
  - Required response: Ring inject at cycle 1 with tid=2, OutstandingRd=4'b0100. RD_RSP T2 data 0xDEAD_BEEF at cycle 5 gives C2F_RspValidQ502H=1 at cycle 6 with data 0xDEAD_BEEF, tid=2, and OutstandingRd=0.
- Full and back-pressure:
  - Stimulus: RingSlotFree=0, push 4 WRs on consecutive cycles.
  - Required response: C2F_RspStall=1 from the cycle after the 4th push. Raise SlotFree: 4 injects in order over 4 cycles, stall drops after the first pop.
- Simultaneous push and pop at full:
  - Stimulus: FIFO full, SlotFree=1 and push in the same cycle.
  - Required response: count stays 4, FIFO order preserved, no entry lost. Check over 8 requests spanning pointer wrap.
- Spurious response:
  - Stimulus: RD_RSP T1 with OutstandingRd=0.
  - Required response: no C2F_RspValid, SpuriousRspErr=1 and it stays set.
- Reset mid-operation:
  - Stimulus: 3 entries queued, T0 read outstanding, RstQnnnH=1 for 1 cycle.
  - Required response: next cycle all outputs 0, no inject even with SlotFree=1.
- All threads:
  - Stimulus: RD from T0–T3 back-to-back, responses returned in order 3,0,2,1.
  - Required response: each response is routed with its correct tid and data, and OutstandingRd clears bit-by-bit to 0.
